// File: rtl/win5x5_line_ctrl.sv
// win5x5_line_ctrl: sequencer for a 5x5 line-buffer window generator.
// Tracks the pixel position in the frame, drives four line-buffer FIFO
// write/read enables, appends two flush lines after the last real pixel,
// and emits a centre-row-aligned valid together with the centre coordinates.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   din_vld     real pixel strobe from the source
//   pix_stb     window shift enable (din_vld, or the internal flush strobe)
//   wr_en/rd_en FIFO enables, bit k = line buffer with row delay k+1
//   flush_act   window mux selects FIFO data instead of din
//   top_lvl     real rows above the newest row, saturated at 4
//   bot_lvl     flush line in progress (0, 1, 2)
//   ctr_vld     centre row of the window is a real image row
//   ctr_row     centre row index, ctr_col column of the newest window column
//   frame_done  one-cycle pulse after the last flush strobe
//   busy        frame in progress, err_ovf sticky din_vld-during-flush flag
module win5x5_line_ctrl #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_vld,
    output logic        pix_stb,
    output logic [3:0]  wr_en,
    output logic [3:0]  rd_en,
    output logic        flush_act,
    output logic [2:0]  top_lvl,
    output logic [1:0]  bot_lvl,
    output logic        ctr_vld,
    output logic [11:0] ctr_row,
    output logic [11:0] ctr_col,
    output logic        frame_done,
    output logic        busy,
    output logic        err_ovf
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;
    logic [11:0] col, row_ext;
    logic last_col, last_real, last_flush;
    assign last_col   = col == 12'(H_DISP - 1);
    assign last_real  = last_col && row_ext == 12'(V_DISP - 1);
    assign last_flush = last_col && row_ext == 12'(V_DISP + 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = din_vld ? RUN : IDLE;
            RUN:     state_nxt = (din_vld && last_real) ? FLUSH : RUN;
            FLUSH:   state_nxt = last_flush ? IDLE : FLUSH;
            default: state_nxt = IDLE;
        endcase
    end
    // Row r is written into buffer k while it is still needed k+1 rows
    // later, and read back once the buffer holds a row (r >= k+1).
    always_comb begin
        flush_act = state == FLUSH;
        pix_stb   = flush_act ? 1'b1 : din_vld;
        for (int k = 0; k < 4; k++) begin
            wr_en[k] = pix_stb && row_ext <= 12'(V_DISP - k);
            rd_en[k] = pix_stb && row_ext >= 12'(k + 1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row_ext <= '0;
        end else if (pix_stb) begin
            col     <= last_col ? 12'd0 : col + 12'd1;
            row_ext <= !last_col ? row_ext : last_flush ? 12'd0 : row_ext + 12'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_lvl    <= '0;
            bot_lvl    <= '0;
            ctr_vld    <= 1'b0;
            ctr_row    <= '0;
            ctr_col    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            ctr_vld    <= pix_stb && row_ext >= 12'd2;
            frame_done <= flush_act && last_flush;
            busy       <= state_nxt != IDLE;
            if (state == IDLE && din_vld)
                err_ovf <= 1'b0;
            else if (flush_act && din_vld)
                err_ovf <= 1'b1;
            if (pix_stb) begin
                top_lvl <= row_ext >= 12'd4 ? 3'd4 : row_ext[2:0];
                // flush rows are exactly row_ext V_DISP and V_DISP+1
                bot_lvl <= !flush_act ? 2'd0 : row_ext == 12'(V_DISP) ? 2'd1 : 2'd2;
                ctr_row <= row_ext - 12'd2;
                ctr_col <= col;
            end
        end
    end
endmodule

// File: tb/tb_win5x5_line_ctrl.sv
// tb_win5x5_line_ctrl: randomized self-checking bench with a frame-position reference model.
module tb_win5x5_line_ctrl;
    localparam int H = 8, V = 6, NP = H * V, NS = H * (V + 2);
    logic clk = 1'b0, rst_n = 1'b0, din_vld = 1'b0;
    logic pix_stb, flush_act, ctr_vld, frame_done, busy, err_ovf;
    logic [3:0] wr_en, rd_en;
    logic [2:0] top_lvl;
    logic [1:0] bot_lvl;
    logic [11:0] ctr_row, ctr_col;
    win5x5_line_ctrl #(.H_DISP(H), .V_DISP(V)) dut (
        .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .pix_stb(pix_stb),
        .wr_en(wr_en), .rd_en(rd_en), .flush_act(flush_act), .top_lvl(top_lvl),
        .bot_lvl(bot_lvl), .ctr_vld(ctr_vld), .ctr_row(ctr_row), .ctr_col(ctr_col),
        .frame_done(frame_done), .busy(busy), .err_ovf(err_ovf)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // model: frame position is simply the number of strobes taken so far
    bit m_act = 0, m_cvld = 0, m_done = 0, m_busy = 0, m_err = 0;
    int m_n = 0, m_top = 0, m_bot = 0, m_ccol = 0;
    logic [11:0] m_crow = '0;
    int occ[4] = '{0, 0, 0, 0};
    int stb_total = 0, cv_total = 0, done_cnt = 0, done_at = 0, flush_tot = 0;
    int wr_tot[4] = '{0, 0, 0, 0}, rd_tot[4] = '{0, 0, 0, 0};
    logic [23:0] cv_log[0:1023];
    int cv_at[0:1023];
    always @(negedge clk) begin
        int r, c;
        bit fl, stb;
        logic [3:0] ew, er;
        if (!rst_n) begin
            m_act = 0; m_n = 0; m_top = 0; m_bot = 0; m_cvld = 0; m_crow = '0;
            m_ccol = 0; m_done = 0; m_busy = 0; m_err = 0;
            for (int k = 0; k < 4; k++) occ[k] = 0;
        end
        fl = m_act && m_n >= NP;
        stb = fl || din_vld;
        r = m_n / H;
        c = m_n % H;
        for (int k = 0; k < 4; k++) begin
            ew[k] = stb && r <= V - k;
            er[k] = stb && r >= k + 1;
        end
        check("pix_stb", pix_stb, stb);
        check("flush_act", flush_act, fl);
        check("wr_en", wr_en, ew);
        check("rd_en", rd_en, er);
        check("top_lvl", top_lvl, m_top);
        check("bot_lvl", bot_lvl, m_bot);
        check("ctr_vld", ctr_vld, m_cvld);
        if (m_cvld) begin
            check("ctr_row", ctr_row, m_crow);
            check("ctr_col", ctr_col, m_ccol);
        end
        check("frame_done", frame_done, m_done);
        check("busy", busy, m_busy);
        check("err_ovf", err_ovf, m_err);
        if (ctr_vld) begin
            cv_log[cv_total] = {ctr_row, ctr_col};
            cv_at[cv_total] = stb_total;
            cv_total++;
        end
        if (frame_done) begin
            done_cnt++;
            done_at = stb_total;
            check("fifo_empty", {occ[0][7:0], occ[1][7:0], occ[2][7:0], occ[3][7:0]}, 0);
        end
        if (rst_n) begin
            if (pix_stb) stb_total++;
            if (flush_act) flush_tot++;
            for (int k = 0; k < 4; k++) begin
                wr_tot[k] += int'(wr_en[k]);
                rd_tot[k] += int'(rd_en[k]);
                occ[k] += int'(wr_en[k]) - int'(rd_en[k]);
            end
            m_done = 0;
            m_cvld = 0;
            if (!m_act && din_vld) m_err = 0;
            else if (fl && din_vld) m_err = 1;
            if (stb) begin
                m_top = r > 4 ? 4 : r;
                m_bot = r >= V ? r - V + 1 : 0;
                m_cvld = r >= 2;
                m_crow = 12'(r - 2);
                m_ccol = c;
                m_act = 1;
                if (m_n == NS - 1) begin
                    m_done = 1; m_act = 0; m_n = 0;
                end else m_n++;
            end
            m_busy = m_act;
        end
    end
    task automatic drive_pixels(input int n);
        din_vld = 1'b1;
        repeat (n) @(posedge clk);
        #1 din_vld = 1'b0;
    endtask
    task automatic run_frame(input bit gaps, input bit fdin);
        int acc = 0, w = 0, d0 = done_cnt;
        bit v;
        while (acc < NP) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            din_vld = v;
            @(posedge clk);
            #1;
            if (v) acc++;
        end
        din_vld = fdin;
        repeat (2 * H) @(posedge clk);
        #1 din_vld = 1'b0;
        while (done_cnt == d0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (done_cnt == d0) check("frame_done_timeout", 0, 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int s0, c0, c1, f0, bad;
        int w0[4], r0[4];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_top", top_lvl, 0);
        // frame 1: contiguous
        s0 = stb_total; c0 = cv_total; f0 = flush_tot;
        for (int k = 0; k < 4; k++) begin w0[k] = wr_tot[k]; r0[k] = rd_tot[k]; end
        run_frame(0, 0);
        check("f1_cvld_count", cv_total - c0, 48);
        check("f1_first_cvld_after", cv_at[c0] - s0, 17);
        check("f1_first_cvld_pos", cv_log[c0], 0);
        check("f1_last_cvld_pos", cv_log[c0 + 47], 24'h005007);
        check("f1_done_after", done_at - s0, 64);
        check("f1_flush_len", flush_tot - f0, 16);
        for (int k = 0; k < 4; k++) begin
            check("f1_wr_count", wr_tot[k] - w0[k], 8 * (7 - k));
            check("f1_rd_count", rd_tot[k] - r0[k], 8 * (7 - k));
        end
        check("f1_top_end", top_lvl, 4);
        check("f1_bot_end", bot_lvl, 2);
        check("f1_busy_end", busy, 0);
        // frame 2: random din_vld gaps must yield the same centre sequence
        c1 = cv_total;
        run_frame(1, 0);
        check("f2_cvld_count", cv_total - c1, 48);
        bad = 0;
        for (int i = 0; i < 48; i++) if (cv_log[c1 + i] !== cv_log[c0 + i]) bad++;
        check("f2_sequence", bad, 0);
        // frame 3: din_vld held during flush
        c1 = cv_total; f0 = flush_tot;
        run_frame(0, 1);
        check("f3_err_ovf", err_ovf, 1);
        check("f3_flush_len", flush_tot - f0, 16);
        check("f3_cvld_count", cv_total - c1, 48);
        // frame 4: first pixel clears the error, reset at pixel 20
        drive_pixels(1);
        check("f4_err_clear", err_ovf, 0);
        check("f4_busy", busy, 1);
        drive_pixels(19);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_outputs", {top_lvl, bot_lvl, ctr_vld, ctr_row, ctr_col, frame_done, err_ovf}, 0);
        check("rst_enables", {pix_stb, wr_en, rd_en, flush_act}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // frame 5: fresh frame after reset
        c1 = cv_total; s0 = stb_total;
        run_frame(0, 0);
        check("f5_cvld_count", cv_total - c1, 48);
        check("f5_done_after", done_at - s0, 64);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
